// File: rtl/stream_chk_pkg.sv
// Shared types for the stream checker: mismatch record layout, FSM states, default key.
package stream_chk_pkg;

  localparam int CHK_DW = 16;
  localparam logic [CHK_DW-1:0] DEF_XOR_KEY = 16'h00FF;

  typedef struct packed {
    logic [CHK_DW-1:0] instr;
    logic [CHK_DW-1:0] result;
    logic [CHK_DW-1:0] expected;
  } chk_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_t;

endpackage

// File: rtl/chk_fifo.sv
// Synchronous mismatch-record FIFO; push while full is accepted only when a pop frees a slot.
module chk_fifo
  import stream_chk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  chk_rec_t wr_rec,
  output chk_rec_t rd_rec,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  chk_rec_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_rec;
  end

  // Masked so the record outputs read zero whenever nothing is queued.
  assign rd_rec = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/stream_checker.sv
// Checks result == instr ^ XOR_KEY on every beat, counts outcomes and queues mismatch records.
// Define SEQ_CHECK_EN to also check that instructions arrive in +1 sequence.
module stream_checker
  import stream_chk_pkg::*;
#(
  parameter int             DW         = CHK_DW,
  parameter logic [DW-1:0]  XOR_KEY    = DEF_XOR_KEY,
  parameter int             FIFO_DEPTH = 4,
  parameter int             CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_instr,
  input  logic [DW-1:0]    in_result,
  input  logic             clear,
  input  logic             halt_on_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_instr,
  output logic [DW-1:0]    out_result,
  output logic [DW-1:0]    out_expected,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow,
  output logic             halted
`ifdef SEQ_CHECK_EN
  ,
  output logic [CNT_W-1:0] seq_err_count
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  chk_state_t    state;
  logic          vld_p0;
  logic [DW-1:0] instr_p0;
  logic [DW-1:0] result_p0;
  logic          vld_p1;
  logic [DW-1:0] instr_p1;
  logic [DW-1:0] result_p1;
  logic [DW-1:0] expected_p1;
  logic          match_p1;

  logic          capture;
  logic          count_en;
  logic          mismatch;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;
  chk_rec_t      wr_rec;
  chk_rec_t      rd_rec;

  assign capture  = in_valid && (state != HALT) && !clear;
  assign count_en = vld_p1 && (state != HALT);
  assign mismatch = count_en && !match_p1;
  assign pop      = out_valid && out_ready;
  assign drop     = mismatch && fifo_full && !pop;

  // Stage 0: register the incoming beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (clear) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= capture;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      instr_p0  <= in_instr;
      result_p0 <= in_result;
    end
    // Stage 1: reference model and compare.
    if (vld_p0) begin
      instr_p1    <= instr_p0;
      result_p1   <= result_p0;
      expected_p1 <= instr_p0 ^ XOR_KEY;
      match_p1    <= (result_p0 == (instr_p0 ^ XOR_KEY));
    end
  end

  // Stage 2: FSM, counters and record push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pass_count <= '0;
      err_count  <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      pass_count <= '0;
      err_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid) state <= RUN;
        RUN:     if (mismatch && halt_on_err) state <= HALT;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
      if (count_en) begin
        if (match_p1) pass_count <= sat_inc(pass_count);
        else          err_count  <= sat_inc(err_count);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign halted = (state == HALT);

`ifdef SEQ_CHECK_EN
  logic [DW-1:0] prev_instr;
  logic          have_base;
  logic          seq_break;

  // The first counted beat after reset/clear only establishes the baseline.
  assign seq_break = count_en && have_base && (instr_p1 != prev_instr + DW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_base     <= 1'b0;
      seq_err_count <= '0;
    end else if (clear) begin
      have_base     <= 1'b0;
      seq_err_count <= '0;
    end else begin
      if (count_en)  have_base     <= 1'b1;
      if (seq_break) seq_err_count <= sat_inc(seq_err_count);
    end
  end

  always_ff @(posedge clk) begin
    if (count_en) prev_instr <= instr_p1;
  end
`endif

  assign wr_rec.instr    = instr_p1;
  assign wr_rec.result   = result_p1;
  assign wr_rec.expected = expected_p1;

  chk_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (clear),
    .push   (mismatch),
    .pop    (pop),
    .wr_rec (wr_rec),
    .rd_rec (rd_rec),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_instr    = rd_rec.instr;
  assign out_result   = rd_rec.result;
  assign out_expected = rd_rec.expected;

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: expected records queued at drive time, popped on handshake.
module tb_stream_checker;

  localparam int DW = 16;
  localparam int CNT_W = 16;
  localparam int FIFO_DEPTH = 4;
  localparam logic [15:0] KEY = 16'h00FF;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] result;
    logic [15:0] expected;
  } rec_t;

  logic clk = 1'b0;
  logic reset, in_valid, clear, halt_on_err, out_ready;
  logic [DW-1:0] in_instr, in_result;
  logic out_valid, overflow, halted;
  logic [DW-1:0] out_instr, out_result, out_expected;
  logic [CNT_W-1:0] pass_count, err_count;
`ifdef SEQ_CHECK_EN
  logic [CNT_W-1:0] seq_err_count;
`endif

  int checks = 0;
  int errors = 0;
  rec_t sb[$];
  rec_t mon_rec;
  rec_t got_rec;
  int exp_pass, exp_err;
  logic exp_ovf;

  always #5 clk = ~clk;

  stream_checker dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_result    (in_result),
    .clear        (clear),
    .halt_on_err  (halt_on_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_result   (out_result),
    .out_expected (out_expected),
    .pass_count   (pass_count),
    .err_count    (err_count),
    .overflow     (overflow),
    .halted       (halted)
`ifdef SEQ_CHECK_EN
    ,
    .seq_err_count(seq_err_count)
`endif
  );

  // Inputs change #1 after posedge, so at negedge out_valid/out_ready show the coming handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_rec = {out_instr, out_result, out_expected};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h/%h/%h, required no record", out_instr, out_result, out_expected);
      end else begin
        mon_rec = sb.pop_front();
        if (got_rec !== mon_rec) begin
          errors++;
          $display("FAIL pop_record: got %h/%h/%h, required %h/%h/%h", out_instr, out_result, out_expected,
                   mon_rec.instr, mon_rec.result, mon_rec.expected);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] i, input logic [15:0] r, input bit counted);
    rec_t e;
    in_valid  = 1'b1;
    in_instr  = i;
    in_result = r;
    if (counted) begin
      if (r !== (i ^ KEY)) begin
        exp_err++;
        e = {i, r, i ^ KEY};
        if (sb.size() < FIFO_DEPTH) sb.push_back(e);
        else exp_ovf = 1'b1;
      end else begin
        exp_pass++;
      end
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    sb.delete();
    exp_pass = 0;
    exp_err  = 0;
    exp_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_result = '0;
    clear = 1'b0; halt_on_err = 1'b0; out_ready = 1'b1;
    exp_pass = 0; exp_err = 0; exp_ovf = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (pass_count !== '0) begin errors++; $display("FAIL reset_pass: got %0d, required 0", pass_count); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err: got %0d, required 0", err_count); end
    checks++; if (overflow !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b halted=%b, required 0 0", overflow, halted); end
    checks++; if ({out_instr, out_result, out_expected} !== '0) begin errors++; $display("FAIL reset_record: got %h/%h/%h, required 0", out_instr, out_result, out_expected); end
  endtask

  task automatic test_back_to_back();
    logic any_valid;
    any_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat(16'(i), 16'(i) ^ KEY, 1'b1);
      any_valid |= out_valid;
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      any_valid |= out_valid;
    end
    checks++; if (pass_count !== CNT_W'(exp_pass)) begin errors++; $display("FAIL b2b_pass: got %0d, required %0d", pass_count, exp_pass); end
    checks++; if (err_count !== CNT_W'(exp_err)) begin errors++; $display("FAIL b2b_err: got %0d, required %0d", err_count, exp_err); end
    checks++; if (any_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid: got %b, required 0", any_valid); end
  endtask

  task automatic test_mismatch();
    rec_t first;
    out_ready = 1'b0;
    beat(16'h0003, 16'h0000, 1'b1);
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mm_latency_early: got %b, required 0", out_valid); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mm_latency: got %b, required 1", out_valid); end
    checks++; if (err_count !== CNT_W'(exp_err)) begin errors++; $display("FAIL mm_err: got %0d, required %0d", err_count, exp_err); end
    first = {out_instr, out_result, out_expected};
    checks++; if (first !== {16'h0003, 16'h0000, 16'h00FC}) begin errors++; $display("FAIL mm_record: got %h, required 0003/0000/00fc", first); end
    step(3);
    checks++; if (out_valid !== 1'b1 || {out_instr, out_result, out_expected} !== {16'h0003, 16'h0000, 16'h00FC}) begin
      errors++; $display("FAIL mm_hold: got %b %h/%h/%h, required 1 0003/0000/00fc", out_valid, out_instr, out_result, out_expected);
    end
    out_ready = 1'b1;
    step(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mm_pop: got %b, required 0", out_valid); end
    checks++; if (pass_count !== CNT_W'(exp_pass)) begin errors++; $display("FAIL mm_pass: got %0d, required %0d", pass_count, exp_pass); end
  endtask

  task automatic test_overflow();
    do_clear();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) beat(16'(i), 16'h0000, 1'b1);
    step(3);
    checks++; if (err_count !== CNT_W'(exp_err)) begin errors++; $display("FAIL ovf_err: got %0d, required %0d", err_count, exp_err); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag: got %b, required %b", overflow, exp_ovf); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b, required 1", out_valid); end
    out_ready = 1'b1;
    step(8);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ovf_drain: got %0d records left, required 0", sb.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b, required 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_halt();
    do_clear();
    out_ready   = 1'b1;
    halt_on_err = 1'b1;
    beat(16'h0010, 16'h0010 ^ KEY, 1'b1);
    beat(16'h0011, 16'h0000, 1'b1);
    beat(16'h0012, 16'h0012 ^ KEY, 1'b0);
    beat(16'h0013, 16'h0000, 1'b0);
    beat(16'h0014, 16'h0014 ^ KEY, 1'b0);
    step(4);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b, required 1", halted); end
    checks++; if (pass_count !== CNT_W'(exp_pass)) begin errors++; $display("FAIL halt_pass: got %0d, required %0d", pass_count, exp_pass); end
    checks++; if (err_count !== CNT_W'(exp_err)) begin errors++; $display("FAIL halt_err: got %0d, required %0d", err_count, exp_err); end
    checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain: got %0d left valid=%b, required 0 0", sb.size(), out_valid); end
    do_clear();
    halt_on_err = 1'b0;
    step(1);
    checks++; if (halted !== 1'b0 || pass_count !== '0 || err_count !== '0) begin
      errors++; $display("FAIL halt_clear: got halted=%b pass=%0d err=%0d, required 0 0 0", halted, pass_count, err_count);
    end
  endtask

`ifdef SEQ_CHECK_EN
  task automatic test_seq();
    do_clear();
    beat(16'hFFFE, 16'hFFFE ^ KEY, 1'b1);
    beat(16'hFFFF, 16'hFFFF ^ KEY, 1'b1);
    beat(16'h0000, 16'h0000 ^ KEY, 1'b1);
    step(2);
    checks++; if (seq_err_count !== '0) begin errors++; $display("FAIL seq_wrap: got %0d, required 0", seq_err_count); end
    beat(16'h0002, 16'h0002 ^ KEY, 1'b1);
    step(2);
    checks++; if (seq_err_count !== CNT_W'(1)) begin errors++; $display("FAIL seq_break: got %0d, required 1", seq_err_count); end
    checks++; if (pass_count !== CNT_W'(exp_pass) || out_valid !== 1'b0) begin
      errors++; $display("FAIL seq_pass: got %0d valid=%b, required %0d 0", pass_count, out_valid, exp_pass);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_clear();
    out_ready = 1'b0;
    beat(16'h0020, 16'h0000, 1'b1);
    beat(16'h0021, 16'h0000, 1'b1);
    step(2);
    checks++; if (out_valid !== 1'b1 || err_count !== CNT_W'(exp_err)) begin
      errors++; $display("FAIL rmid_pre: got valid=%b err=%0d, required 1 %0d", out_valid, err_count, exp_err);
    end
    reset = 1'b1;
    sb.delete();
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, required 0", out_valid); end
    checks++; if (err_count !== '0 || pass_count !== '0) begin errors++; $display("FAIL rmid_counts: got pass=%0d err=%0d, required 0 0", pass_count, err_count); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rmid_halted: got %b, required 0", halted); end
    reset = 1'b0;
    out_ready = 1'b1;
    step(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_record: got %b, required 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mismatch();
    test_overflow();
    test_halt();
`ifdef SEQ_CHECK_EN
    test_seq();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
